// File: rtl/quadratic_seq.sv
// rtl/quadratic_seq.sv - multicycle Horner-rule quadratic evaluator y = a*x^2 + b*x + c
// One shared signed multiplier; the FSM sequences t = a*x>>>F + b, then r = t*x>>>F + c with saturation.
module quadratic_seq #(
    parameter int WIDTH = 10,
    parameter int FRAC  = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic signed [WIDTH-1:0] c,
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH-1:0] y,
    output logic                    ovf
);

    localparam int TW = 2 * WIDTH + 1;
    localparam int PW = 3 * WIDTH + 1;
    localparam int RW = 3 * WIDTH + 2;

    localparam logic signed [RW-1:0] R_MAX = {{(RW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [RW-1:0] R_MIN = {{(RW - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP1 = 2'd1,
        STEP2 = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state_q;
    logic signed [WIDTH-1:0] x_q, a_q, b_q, c_q, y_q;
    logic signed [TW-1:0]    t_q, t_d;
    logic                    busy_q, done_q, ovf_q;

    logic signed [PW-1:0]    mul_op, mul_x, prod, prod_sh;
    logic signed [RW-1:0]    r_d;
    logic signed [WIDTH-1:0] y_d;
    logic                    ovf_d;

    // The multiplier's first operand is a in STEP1 and the intermediate t in STEP2.
    always_comb begin
        mul_op = {{(PW - WIDTH){a_q[WIDTH-1]}}, a_q};
        if (state_q == STEP2) begin
            mul_op = {{(PW - TW){t_q[TW-1]}}, t_q};
        end
        mul_x   = {{(PW - WIDTH){x_q[WIDTH-1]}}, x_q};
        prod    = mul_op * mul_x;
        prod_sh = prod >>> FRAC;

        t_d = prod_sh[TW-1:0] + {{(TW - WIDTH){b_q[WIDTH-1]}}, b_q};
        r_d = {prod_sh[PW-1], prod_sh} + {{(RW - WIDTH){c_q[WIDTH-1]}}, c_q};

        y_d   = r_d[WIDTH-1:0];
        ovf_d = 1'b0;
        if (r_d > R_MAX) begin
            y_d   = {1'b0, {(WIDTH - 1){1'b1}}};
            ovf_d = 1'b1;
        end else if (r_d < R_MIN) begin
            y_d   = {1'b1, {(WIDTH - 1){1'b0}}};
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            t_q     <= '0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        x_q     <= x;
                        a_q     <= a;
                        b_q     <= b;
                        c_q     <= c;
                        busy_q  <= 1'b1;
                        state_q <= STEP1;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                STEP1: begin
                    t_q     <= t_d;
                    state_q <= STEP2;
                end
                STEP2: begin
                    y_q     <= y_d;
                    ovf_q   <= ovf_d;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign y    = y_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_quadratic_seq.sv
// tb/tb_quadratic_seq.sv - directed bench for quadratic_seq with a result scoreboard
module tb_quadratic_seq;

    localparam int W = 10;
    localparam int F = 5;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic signed [W-1:0] x, a, b, c;
    logic                busy, done, ovf;
    logic signed [W-1:0] y;

    int errors = 0;
    int checks = 0;
    logic [W:0] sb[$];

    quadratic_seq #(.WIDTH(W), .FRAC(F)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .x     (x),
        .a     (a),
        .b     (b),
        .c     (c),
        .busy  (busy),
        .done  (done),
        .y     (y),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: floor shifts on 64-bit integers, then clip to the output range.
    function automatic logic [W:0] model(input int av, input int bv, input int cv, input int xv);
        longint t, r, ymax, ymin;
        logic [W-1:0] yv;
        logic ov;
        ymax = (longint'(1) <<< (W - 1)) - 1;
        ymin = -(longint'(1) <<< (W - 1));
        t = ((longint'(av) * longint'(xv)) >>> F) + longint'(bv);
        r = ((t * longint'(xv)) >>> F) + longint'(cv);
        ov = 1'b0;
        if (r > ymax) begin r = ymax; ov = 1'b1; end
        else if (r < ymin) begin r = ymin; ov = 1'b1; end
        yv = r[W-1:0];
        return {ov, yv};
    endfunction

    always @(posedge clk) begin
        #1;
        if (done) begin
            logic [W:0] e;
            check("done_busy_excl", int'(busy), 0);
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("sb_y", int'(y), int'($signed(e[W-1:0])));
                check("sb_ovf", int'(ovf), int'(e[W]));
            end
        end
    end

    task automatic drive(input int av, input int bv, input int cv, input int xv);
        a = av[W-1:0];
        b = bv[W-1:0];
        c = cv[W-1:0];
        x = xv[W-1:0];
    endtask

    task automatic run_eval(input int av, input int bv, input int cv, input int xv);
        drive(av, bv, cv, xv);
        start = 1'b1;
        sb.push_back(model(av, bv, cv, xv));
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_c1", int'(busy), 1);
        check("done_c1", int'(done), 0);
        @(posedge clk); #1;
        check("busy_c2", int'(busy), 1);
        @(posedge clk); #1;
        check("done_latency", int'(done), 1);
    endtask

    initial begin
        int dcyc[$];
        reset = 1'b1;
        start = 1'b1;
        drive(32, 0, 0, 64);
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_y", int'(y), 0);
        check("rst_ovf", int'(ovf), 0);
        reset = 1'b0;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("idle_busy", int'(busy), 0);
            check("idle_done", int'(done), 0);
        end

        run_eval(32, 0, 0, 64);
        check("basic_y", int'(y), 128);
        check("basic_ovf", int'(ovf), 0);
        @(posedge clk); #1;
        check("done_one_cycle", int'(done), 0);

        run_eval(32, -64, 32, 32);
        check("cancel_y", int'(y), 0);
        run_eval(0, -1, 0, 32);
        check("floor_y", int'(y), -1);

        run_eval(32, 0, 0, 256);
        check("satp_y", int'(y), 511);
        check("satp_ovf", int'(ovf), 1);
        run_eval(-32, 0, 0, 256);
        check("satn_y", int'(y), -512);
        check("satn_ovf", int'(ovf), 1);
        run_eval(32, 0, 0, 64);
        check("ovf_clear", int'(ovf), 0);

        // Start re-pulsed and operands changed while busy must not disturb the accepted job.
        @(posedge clk); #1;
        drive(32, 0, 0, 32);
        start = 1'b1;
        sb.push_back(model(32, 0, 0, 32));
        @(posedge clk); #1;
        drive(-32, 0, 0, 64);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("ignore_done", int'(done), 1);
        check("ignore_y", int'(y), 32);

        drive(32, 16, -32, 40);
        start = 1'b1;
        repeat (3) sb.push_back(model(32, 16, -32, 40));
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) dcyc.push_back(i);
            if (i == 8) start = 1'b0;
        end
        check("held_count", dcyc.size(), 3);
        if (dcyc.size() == 3) begin
            check("held_first", dcyc[0], 2);
            check("held_gap1", dcyc[1] - dcyc[0], 3);
            check("held_gap2", dcyc[2] - dcyc[1], 3);
        end
        while (sb.size() > 0) void'(sb.pop_front());

        drive(32, 0, 0, 64);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("abort_in_step2", int'(busy), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_y", int'(y), 0);
        check("abort_busy", int'(busy), 0);
        repeat (4) begin
            check("abort_no_done", int'(done), 0);
            @(posedge clk); #1;
        end

        for (int xv = -512; xv <= 511; xv += 8) begin
            run_eval(32, 16, -32, xv);
        end
        @(posedge clk); #1;
        check("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
